// File: rtl/spm_arb_pkg.sv
// Shared types and helpers for the single-port SPM arbiter.
// Holds the controller state encoding and the round-robin winner search
// used by the combinational arbiter.
package spm_arb_pkg;

    // Controller states: zero-fill the array, then serve requesters.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } arb_state_e;

    // Widest requester vector the search helper handles.
    localparam int unsigned MaxReq = 32'd32;

    // Round-robin search: scan from ptr upwards, wrapping modulo num_req, and
    // return the index of the first set bit of valid. found flags a winner;
    // with no winner the returned index is 0.
    function automatic int unsigned rr_search(
        input  logic [MaxReq-1:0] valid,
        input  int unsigned       ptr,
        input  int unsigned       num_req,
        output logic              found
    );
        int unsigned cand;
        int unsigned winner;
        found  = 1'b0;
        winner = 32'd0;
        for (int unsigned i = 32'd0; i < MaxReq; i++) begin
            if (i < num_req) begin
                cand = ptr + i;
                if (cand >= num_req) begin
                    cand = cand - num_req;
                end else begin
                    cand = cand;
                end
                if (!found && valid[cand[4:0]]) begin
                    found  = 1'b1;
                    winner = cand;
                end else begin
                    found  = found;
                end
            end else begin
                cand = 32'd0;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/spm_rr_arbiter.sv
// Purely combinational round-robin arbiter: picks the first valid requester
// at or after the pointer (wrapping) and reports it as one-hot and as index.
module spm_rr_arbiter
    import spm_arb_pkg::*;
#(
    parameter int unsigned NumReq   = 32'd2,
    parameter int unsigned IdxWidth = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1
) (
    input  logic [NumReq-1:0]   valid,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   grant,
    output logic [IdxWidth-1:0] idx,
    output logic                any_grant
);

    logic                found_s;
    logic [IdxWidth-1:0] idx_s;

    // Winner search and one-hot grant decode.
    always_comb begin
        found_s = 1'b0;
        idx_s   = IdxWidth'(rr_search(MaxReq'(valid), 32'(ptr), NumReq, found_s));
        grant   = '0;
        if (found_s) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
        idx       = idx_s;
        any_grant = found_s;
    end

endmodule

// File: rtl/spm_1p_port_arbiter.sv
// Shares one single-port, latency-1 SPM macro between NumReq requesters.
// After reset an optional clear phase zero-fills the array; afterwards one
// round-robin grant is issued per cycle and read data is returned to the
// granted requester exactly one cycle after its grant.
module spm_1p_port_arbiter
    import spm_arb_pkg::*;
#(
    parameter int unsigned NumReq       = 32'd2,
    parameter int unsigned NumWords     = 32'd1024,
    parameter int unsigned DataWidth    = 32'd128,
    parameter int unsigned ByteWidth    = 32'd8,
    parameter logic        ClearOnReset = 1'b1,
    localparam int unsigned AddrWidth   = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
    localparam int unsigned BeWidth     = (DataWidth + ByteWidth - 32'd1) / ByteWidth,
    localparam int unsigned IdxWidth    = (NumReq > 32'd1) ? $clog2(NumReq) : 32'd1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    input  logic [NumReq-1:0]                  req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   req_wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]     req_be_i,
    output logic [NumReq-1:0]                  rsp_valid_o,
    output logic [DataWidth-1:0]               rsp_rdata_o,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [AddrWidth-1:0]               mem_addr_o,
    output logic [DataWidth-1:0]               mem_wdata_o,
    output logic [BeWidth-1:0]                 mem_be_o,
    input  logic [DataWidth-1:0]               mem_rdata_i,
    output logic                               init_busy_o
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 32'd1);
    localparam logic [IdxWidth-1:0]  LastIdx  = IdxWidth'(NumReq - 32'd1);

    arb_state_e          state_r;
    logic [AddrWidth-1:0] clr_cnt_r;
    logic [IdxWidth-1:0]  ptr_r;
    logic                 rd_pend_r;
    logic [IdxWidth-1:0]  rd_id_r;

    logic [NumReq-1:0]    grant_s;
    logic [IdxWidth-1:0]  win_idx_s;
    logic                 any_grant_s;
    logic                 serve_grant_s;
    logic [IdxWidth-1:0]  ptr_next_s;

    spm_rr_arbiter #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_arbiter (
        .valid     (req_valid_i),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .idx       (win_idx_s),
        .any_grant (any_grant_s)
    );

    // A grant only counts while serving; during clear requests are ignored.
    always_comb begin
        serve_grant_s = (state_r == ST_SERVE) && any_grant_s;
        if (win_idx_s == LastIdx) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_idx_s + IdxWidth'(1);
        end
    end

    // Clear/serve controller with its clear address counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= ClearOnReset ? ST_CLEAR : ST_SERVE;
            clr_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == LastAddr) begin
                        state_r <= ST_SERVE;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + AddrWidth'(1);
                    end
                end
                ST_SERVE: begin
                    state_r <= ST_SERVE;
                end
                default: begin
                    state_r   <= ST_SERVE;
                    clr_cnt_r <= '0;
                end
            endcase
        end
    end

    // Round-robin pointer: moves past the winner on every grant, holds otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_r <= '0;
        end else if (serve_grant_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Read tracking: remember a granted read so its data can be routed next cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_pend_r <= 1'b0;
            rd_id_r   <= '0;
        end else begin
            rd_pend_r <= serve_grant_s && !req_we_i[win_idx_s];
            rd_id_r   <= win_idx_s;
        end
    end

    // Memory port and ready mux: clear writes or the winning requester's access.
    always_comb begin
        req_ready_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        case (state_r)
            ST_CLEAR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = clr_cnt_r;
                mem_be_o   = '1;
            end
            ST_SERVE: begin
                req_ready_o = grant_s;
                if (any_grant_s) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = req_we_i[win_idx_s];
                    mem_addr_o  = req_addr_i[win_idx_s];
                    mem_wdata_o = req_wdata_i[win_idx_s];
                    mem_be_o    = req_be_i[win_idx_s];
                end else begin
                    mem_req_o = 1'b0;
                end
            end
            default: begin
                req_ready_o = '0;
            end
        endcase
    end

    // Response routing: one-cycle pulse to the reader, data gated to zero otherwise.
    always_comb begin
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        if (rd_pend_r) begin
            rsp_valid_o[rd_id_r] = 1'b1;
            rsp_rdata_o          = mem_rdata_i;
        end else begin
            rsp_rdata_o = '0;
        end
    end

    assign init_busy_o = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_spm_1p_port_arbiter.sv
// Directed testbench for spm_1p_port_arbiter with a behavioural latency-1
// byte-enabled SPM model. Inputs change at negedge+1, outputs checked 1 later.
module tb_spm_1p_port_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][3:0]  req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_be;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             mem_req;
    logic             mem_we;
    logic [3:0]       mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic [31:0]      mem_rdata;
    logic             init_busy;

    logic             preload;
    logic [31:0]      mem_q [16];

    int checks;
    int failures;

    spm_1p_port_arbiter #(
        .NumReq       (2),
        .NumWords     (16),
        .DataWidth    (32),
        .ByteWidth    (8),
        .ClearOnReset (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata),
        .init_busy_o (init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SPM model: non-zero preload so the clear is observable, latency-1 reads.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem_q[i] <= 32'hC0DE0000 | 32'(i);
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_q[mem_addr];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic drive(input logic r, input logic v, input logic we,
                         input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid[r] = v;
        req_we[r]    = we;
        req_addr[r]  = a;
        req_wdata[r] = d;
        req_be[r]    = be;
    endtask

    task automatic test_reset_clear();
        rst_n   = 1'b0;
        preload = 1'b1;
        idle_all();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp: got %b want 00", rsp_valid); end
        checks++;
        if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", init_busy); end
        preload = 1'b0;
        rst_n   = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (init_busy !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'(i)
                || mem_wdata !== 32'h0 || mem_be !== 4'hF || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL clear_cycle%0d: busy=%b req=%b we=%b addr=%h wdata=%h be=%h want 1 1 1 %h 0 f",
                         i, init_busy, mem_req, mem_we, mem_addr, mem_wdata, mem_be, 4'(i));
            end
            step();
        end
        checks++;
        if (init_busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL clear_done: busy=%b mem_req=%b want 0 0", init_busy, mem_req);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01 || mem_addr !== 4'd7 || mem_we !== 1'b0) begin
            failures++; $display("FAIL clear_rd_grant: ready=%b addr=%h we=%b want 01 7 0", req_ready, mem_addr, mem_we);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL clear_rd_data: rsp=%b data=%h want 01 00000000", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_write_read();
        step();
        drive(1'b0, 1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        #1;
        checks++;
        if (req_ready !== 2'b01 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd3
            || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'hF) begin
            failures++; $display("FAIL wr_grant: ready=%b we=%b addr=%h wdata=%h be=%h", req_ready, mem_we, mem_addr, mem_wdata, mem_be);
        end
        step();
        drive(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
            failures++; $display("FAIL rd_grant: ready=%b rsp=%b want 01 00", req_ready, rsp_valid);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_rsp: rsp=%b data=%h want 01 deadbeef", rsp_valid, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL rd_pulse_end: rsp=%b data=%h want 00 00000000", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_byte_enable();
        step();
        drive(1'b0, 1'b1, 1'b1, 4'd5, 32'hAAAAAAAA, 4'hF);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL be_fill: ready=%b want 01", req_ready); end
        step();
        idle_all();
        drive(1'b1, 1'b1, 1'b1, 4'd5, 32'h12345678, 4'b0011);
        #1;
        checks++;
        if (req_ready !== 2'b10 || mem_be !== 4'b0011 || mem_wdata !== 32'h12345678) begin
            failures++; $display("FAIL be_write: ready=%b be=%b wdata=%h want 10 0011 12345678", req_ready, mem_be, mem_wdata);
        end
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL be_rd_grant: ready=%b want 10", req_ready); end
        step();
        idle_all();
        #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hAAAA5678) begin
            failures++; $display("FAIL be_rd_data: rsp=%b data=%h want 10 aaaa5678", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_grant;
        logic [1:0]  exp_rsp;
        logic [31:0] exp_data;
        step();
        drive(1'b0, 1'b1, 1'b1, 4'd1, 32'h11111111, 4'hF);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL b2b_pre0: ready=%b want 01", req_ready); end
        step();
        idle_all();
        drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h22222222, 4'hF);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL b2b_pre1: ready=%b want 10", req_ready); end
        step();
        drive(1'b0, 1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01 || mem_addr !== 4'd1) begin
            failures++; $display("FAIL b2b_first: ready=%b addr=%h want 01 1", req_ready, mem_addr);
        end
        for (int i = 1; i < 4; i++) begin
            step();
            exp_grant = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_rsp   = (i % 2 == 1) ? 2'b01 : 2'b10;
            exp_data  = (i % 2 == 1) ? 32'h11111111 : 32'h22222222;
            checks++;
            if (req_ready !== exp_grant || rsp_valid !== exp_rsp || rsp_rdata !== exp_data) begin
                failures++;
                $display("FAIL b2b_cycle%0d: ready=%b rsp=%b data=%h want %b %b %h",
                         i, req_ready, rsp_valid, rsp_rdata, exp_grant, exp_rsp, exp_data);
            end
        end
        step();
        idle_all();
        #1;
        checks++;
        if (req_ready !== 2'b00 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 4'd0
            || mem_wdata !== 32'h0 || mem_be !== 4'h0 || rsp_valid !== 2'b10 || rsp_rdata !== 32'h22222222) begin
            failures++;
            $display("FAIL b2b_idle: ready=%b req=%b we=%b addr=%h wdata=%h be=%h rsp=%b data=%h",
                     req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00) begin failures++; $display("FAIL b2b_end: rsp=%b want 00", rsp_valid); end
    endtask

    task automatic test_reset_drop();
        step();
        drive(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_grant: ready=%b want 01", req_ready); end
        step();
        idle_all();
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || init_busy !== 1'b1) begin
            failures++; $display("FAIL rst_drop: rsp=%b data=%h busy=%b want 00 00000000 1", rsp_valid, rsp_rdata, init_busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clear_ignores_requests();
        drive(1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (req_ready !== 2'b00 || init_busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'(i)) begin
                failures++;
                $display("FAIL clr_hold%0d: ready=%b busy=%b we=%b addr=%h want 00 1 1 %h",
                         i, req_ready, init_busy, mem_we, mem_addr, 4'(i));
            end
            step();
        end
        checks++;
        if (req_ready !== 2'b01 || init_busy !== 1'b0 || mem_addr !== 4'd3) begin
            failures++; $display("FAIL clr_first_grant: ready=%b busy=%b addr=%h want 01 0 3", req_ready, init_busy, mem_addr);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL clr_reread: rsp=%b data=%h want 01 00000000", rsp_valid, rsp_rdata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset_clear();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_reset_drop();
        test_clear_ignores_requests();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
